// File: rtl/lms_sample_feeder.sv
// lms_sample_feeder
// Front end for the LMS adaptive FIR. Buffers the reference (x) and primary (d)
// ADC streams in two small FIFOs, pops them in pairs, delays the primary channel
// by a programmable number of pairs and requantizes both channels to the filter
// input widths.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   enable            1 = run, 0 = flush everything and park in IDLE
//   dly_in            primary delay in samples, captured on IDLE->FILL
//   ref_valid/ready   reference sample handshake, ref_data signed INW bits
//   pri_valid/ready   primary sample handshake, pri_data signed INW bits
//   x_out, d_out      registered requantized pair for the filter
//   smp_strobe        1-cycle pulse when x_out/d_out carry a new pair
//   overflow          sticky desync-flush flag, cleared while enable=0
//   state_out         00 IDLE, 01 FILL, 10 RUN
//
// Build option: LMS_FEED_ROUND_EN selects round-half-up with saturation;
// without it the requantizer is a plain arithmetic-shift truncation.
//
// state | meaning
// IDLE  | disabled, FIFOs held empty, ready low
// FILL  | popping pairs silently until the delay line holds dly_q samples
// RUN   | every pair pop produces a strobe one cycle later

module lms_sample_feeder #(
  parameter int INW    = 16,
  parameter int XW     = 12,
  parameter int DW     = 14,
  parameter int DEPTH  = 8,
  parameter int MAXDLY = 15,
  localparam int DLW   = $clog2(MAXDLY + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DLW-1:0]        dly_in,
  input  logic                  ref_valid,
  input  logic signed [INW-1:0] ref_data,
  output logic                  ref_ready,
  input  logic                  pri_valid,
  input  logic signed [INW-1:0] pri_data,
  output logic                  pri_ready,
  output logic signed [XW-1:0]  x_out,
  output logic signed [DW-1:0]  d_out,
  output logic                  smp_strobe,
  output logic                  overflow,
  output logic [1:0]            state_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10} state_t;

  state_t                state, state_nx;
  logic [AW:0]           ref_wp, ref_rp, pri_wp, pri_rp, ref_cnt, pri_cnt;
  logic [INW-1:0]        ref_mem [DEPTH];
  logic [INW-1:0]        pri_mem [DEPTH];
  logic signed [INW-1:0] dline [MAXDLY];
  logic [DLW-1:0]        dly_q, fill_cnt, dly_load;
  logic                  ref_full, ref_empty, pri_full, pri_empty;
  logic                  ref_wr, pri_wr, pop, pop_ok, desync;
  logic                  flush, load_cnt, set_ovf;
  logic signed [INW-1:0] ref_head, pri_head, pri_dly;

`ifdef LMS_FEED_ROUND_EN
  localparam logic signed [INW:0] XMAX = (INW+1)'(2**(XW-1) - 1);
  localparam logic signed [INW:0] XMIN = -XMAX - 1;
  localparam logic signed [INW:0] DMAX = (INW+1)'(2**(DW-1) - 1);
  localparam logic signed [INW:0] DMIN = -DMAX - 1;
`endif

  function automatic logic signed [XW-1:0] rq_x(input logic signed [INW-1:0] v);
`ifdef LMS_FEED_ROUND_EN
    logic signed [INW:0] s;
    s = $signed({v[INW-1], v}) + $signed((INW+1)'(1) << (INW-XW-1));
    s = s >>> (INW-XW);
    if (s > XMAX) return XMAX[XW-1:0];
    if (s < XMIN) return XMIN[XW-1:0];
    return s[XW-1:0];
`else
    return XW'(v >>> (INW-XW));
`endif
  endfunction

  function automatic logic signed [DW-1:0] rq_d(input logic signed [INW-1:0] v);
`ifdef LMS_FEED_ROUND_EN
    logic signed [INW:0] s;
    s = $signed({v[INW-1], v}) + $signed((INW+1)'(1) << (INW-DW-1));
    s = s >>> (INW-DW);
    if (s > DMAX) return DMAX[DW-1:0];
    if (s < DMIN) return DMIN[DW-1:0];
    return s[DW-1:0];
`else
    return DW'(v >>> (INW-DW));
`endif
  endfunction

  function automatic logic [DLW-1:0] clamp_dly(input logic [DLW-1:0] v);
    if (int'(v) > MAXDLY) return DLW'(MAXDLY);
    return v;
  endfunction

  assign ref_cnt   = ref_wp - ref_rp;
  assign pri_cnt   = pri_wp - pri_rp;
  assign ref_full  = (ref_cnt == (AW+1)'(DEPTH));
  assign pri_full  = (pri_cnt == (AW+1)'(DEPTH));
  assign ref_empty = (ref_cnt == '0);
  assign pri_empty = (pri_cnt == '0);

  // ready comes from registered occupancy only, so a pop never frees a slot
  // for a write in the same cycle.
  assign ref_ready = (state != IDLE) && !ref_full;
  assign pri_ready = (state != IDLE) && !pri_full;
  assign ref_wr    = ref_valid && ref_ready;
  assign pri_wr    = pri_valid && pri_ready;

  assign desync = (state != IDLE) &&
                  ((ref_full && pri_empty) || (pri_full && ref_empty));

  // FILL with nothing left to prime must not consume a pair.
  assign pop_ok = (state == RUN) || ((state == FILL) && (fill_cnt != '0));
  assign pop    = enable && pop_ok && !ref_empty && !pri_empty;

  assign ref_head = ref_mem[ref_rp[AW-1:0]];
  assign pri_head = pri_mem[pri_rp[AW-1:0]];
  assign pri_dly  = (dly_q == '0) ? pri_head : dline[dly_q - 1'b1];

  assign dly_load  = (state == IDLE) ? clamp_dly(dly_in) : dly_q;
  assign state_out = state;

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    load_cnt = 1'b0;
    set_ovf  = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      flush    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nx = FILL;
          flush    = 1'b1;
          load_cnt = 1'b1;
        end
        FILL: begin
          if (desync) begin
            flush    = 1'b1;
            load_cnt = 1'b1;
            set_ovf  = 1'b1;
          end else if (fill_cnt == '0) begin
            state_nx = RUN;
          end else if (pop && (fill_cnt == DLW'(1))) begin
            state_nx = RUN;
          end
        end
        RUN: begin
          if (desync) begin
            state_nx = FILL;
            flush    = 1'b1;
            load_cnt = 1'b1;
            set_ovf  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ref_wr) ref_mem[ref_wp[AW-1:0]] <= ref_data;
    if (pri_wr) pri_mem[pri_wp[AW-1:0]] <= pri_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ref_wp     <= '0;
      ref_rp     <= '0;
      pri_wp     <= '0;
      pri_rp     <= '0;
      dly_q      <= '0;
      fill_cnt   <= '0;
      x_out      <= '0;
      d_out      <= '0;
      smp_strobe <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < MAXDLY; i++) dline[i] <= '0;
    end else begin
      state      <= state_nx;
      smp_strobe <= 1'b0;

      if (!enable)      overflow <= 1'b0;
      else if (set_ovf) overflow <= 1'b1;

      if ((state == IDLE) && enable) dly_q <= dly_load;

      if (load_cnt)                    fill_cnt <= dly_load;
      else if (pop && (state == FILL)) fill_cnt <= fill_cnt - 1'b1;

      if (flush) begin
        ref_wp <= '0;
        ref_rp <= '0;
        pri_wp <= '0;
        pri_rp <= '0;
        for (int i = 0; i < MAXDLY; i++) dline[i] <= '0;
      end else begin
        if (ref_wr) ref_wp <= ref_wp + 1'b1;
        if (pri_wr) pri_wp <= pri_wp + 1'b1;
        if (pop) begin
          ref_rp   <= ref_rp + 1'b1;
          pri_rp   <= pri_rp + 1'b1;
          dline[0] <= pri_head;
          for (int i = 1; i < MAXDLY; i++) dline[i] <= dline[i-1];
          if (state == RUN) begin
            smp_strobe <= 1'b1;
            x_out      <= rq_x(ref_head);
            d_out      <= rq_d(pri_dly);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lms_sample_feeder.sv
module tb_lms_sample_feeder;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  dly_in;
  logic        ref_valid, pri_valid;
  logic [15:0] ref_data, pri_data;
  logic        ref_ready, pri_ready;
  logic [11:0] x_out;
  logic [13:0] d_out;
  logic        smp_strobe, overflow;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  lms_sample_feeder dut (
    .clk(clk), .reset(reset), .enable(enable), .dly_in(dly_in),
    .ref_valid(ref_valid), .ref_data(ref_data), .ref_ready(ref_ready),
    .pri_valid(pri_valid), .pri_data(pri_data), .pri_ready(pri_ready),
    .x_out(x_out), .d_out(d_out), .smp_strobe(smp_strobe),
    .overflow(overflow), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [15:0] p;
    logic [11:0] ex;
    logic [13:0] ed;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rv, input logic [15:0] rd, input logic pv, input logic [15:0] pd);
    ref_valid = rv;
    ref_data  = rd;
    pri_valid = pv;
    pri_data  = pd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] sx [$];
    logic [13:0] sd [$];
    int          wr;
    logic        seen_full;

    vecs[0] = '{16'h1230, 16'h0444, 12'h123, 14'h0111};
    vecs[1] = '{16'h8000, 16'h8000, 12'h800, 14'h2000};
    vecs[3] = '{16'h7FF8, 16'h7FFE, 12'h7FF, 14'h1FFF};
    vecs[5] = '{16'hFFF7, 16'hFFF9, 12'hFFF, 14'h3FFE};
`ifdef LMS_FEED_ROUND_EN
    vecs[2] = '{16'hFFFF, 16'hFFFF, 12'h000, 14'h0000};
    vecs[4] = '{16'h0008, 16'h0002, 12'h001, 14'h0001};
`else
    vecs[2] = '{16'hFFFF, 16'hFFFF, 12'hFFF, 14'h3FFF};
    vecs[4] = '{16'h0008, 16'h0002, 12'h000, 14'h0000};
`endif

    reset  = 1'b0;
    enable = 1'b0;
    dly_in = 4'd0;
    drv(1'b0, 16'h0, 1'b0, 16'h0);

    // reset state
    @(negedge clk);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_d", 32'(d_out), 32'd0);
    check("rst_strobe", 32'(smp_strobe), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ref_ready", 32'(ref_ready), 32'd0);
    check("rst_pri_ready", 32'(pri_ready), 32'd0);

    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("start_fill", 32'(state_out), 32'd1);
    @(negedge clk);
    check("start_run", 32'(state_out), 32'd2);

    // single pairs with zero delay: strobe two edges after the write
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, vecs[i].r, 1'b1, vecs[i].p);
      @(negedge clk);
      drv(1'b0, 16'h0, 1'b0, 16'h0);
      check($sformatf("vec%0d_early_strobe", i), 32'(smp_strobe), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_strobe", i), 32'(smp_strobe), 32'd1);
      check($sformatf("vec%0d_x", i), 32'(x_out), 32'(vecs[i].ex));
      check($sformatf("vec%0d_d", i), 32'(d_out), 32'(vecs[i].ed));
    end

    // delay of 3: three silent pops, then d from pairs 1..3 with x from 4..6
    enable = 1'b0;
    dly_in = 4'd3;
    @(negedge clk);
    check("dly3_idle", 32'(state_out), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("dly3_fill", 32'(state_out), 32'd1);
    for (int c = 0; c < 14; c++) begin
      if (c < 6) drv(1'b1, 16'((c + 1) << 4), 1'b1, 16'((c + 1) << 2));
      else       drv(1'b0, 16'h0, 1'b0, 16'h0);
      @(negedge clk);
      if (smp_strobe) begin
        sx.push_back(x_out);
        sd.push_back(d_out);
      end
    end
    check("dly3_count", 32'(sx.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dly3_x%0d", i), (i < sx.size()) ? 32'(sx[i]) : 32'hFFFF_FFFF, 32'(i + 4));
      check($sformatf("dly3_d%0d", i), (i < sd.size()) ? 32'(sd[i]) : 32'hFFFF_FFFF, 32'(i + 1));
    end
    check("dly3_run", 32'(state_out), 32'd2);

    // desync: reference only, until its FIFO fills
    enable = 1'b0;
    dly_in = 4'd2;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("desync_fill", 32'(state_out), 32'd1);
    drv(1'b1, 16'h0100, 1'b0, 16'h0);
    wr = 0;
    seen_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr++;
      if (!ref_ready) begin
        seen_full = 1'b1;
        break;
      end
    end
    check("desync_full_seen", 32'(seen_full), 32'd1);
    check("desync_writes", 32'(wr), 32'd8);
    check("desync_ovf_before", 32'(overflow), 32'd0);
    @(negedge clk);
    drv(1'b0, 16'h0, 1'b0, 16'h0);
    check("desync_ovf", 32'(overflow), 32'd1);
    check("desync_state", 32'(state_out), 32'd1);
    check("desync_ready_back", 32'(ref_ready), 32'd1);

    // enable dropped mid-burst (dly_q=2 kept after the flush)
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, 16'(k << 4), 1'b1, 16'(k << 2));
      @(negedge clk);
    end
    check("burst_strobe", 32'(smp_strobe), 32'd1);
    check("burst_x", 32'(x_out), 32'd3);
    check("burst_d", 32'(d_out), 32'd1);
    check("burst_ovf", 32'(overflow), 32'd1);
    enable = 1'b0;
    drv(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("drop_state", 32'(state_out), 32'd0);
    check("drop_ref_ready", 32'(ref_ready), 32'd0);
    check("drop_pri_ready", 32'(pri_ready), 32'd0);
    check("drop_strobe", 32'(smp_strobe), 32'd0);
    check("drop_ovf", 32'(overflow), 32'd0);
    check("drop_x_hold", 32'(x_out), 32'd3);
    check("drop_d_hold", 32'(d_out), 32'd1);
    @(negedge clk);
    check("drop_strobe2", 32'(smp_strobe), 32'd0);
    enable = 1'b1;
    dly_in = 4'd0;
    @(negedge clk);
    check("reen_fill", 32'(state_out), 32'd1);
    @(negedge clk);
    check("reen_run", 32'(state_out), 32'd2);
    drv(1'b1, 16'h0500, 1'b1, 16'h0280);
    @(negedge clk);
    drv(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    check("reen_strobe", 32'(smp_strobe), 32'd1);
    check("reen_x", 32'(x_out), 32'h050);
    check("reen_d", 32'(d_out), 32'h0A0);

    // asynchronous reset mid-RUN
    reset = 1'b0;
    #1;
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_x", 32'(x_out), 32'd0);
    check("arst_d", 32'(d_out), 32'd0);
    check("arst_strobe", 32'(smp_strobe), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_ready", 32'({ref_ready, pri_ready}), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("arst_release_fill", 32'(state_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
